// File: rtl/divu_iter_if.sv
// Operand/result handshake bundle for the iterative unsigned divider.
`timescale 1ns/1ps
interface divu_iter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    modport slave (
        input  i_valid, i_dividend, i_divisor, o_ready,
        output i_ready, o_valid, o_quotient, o_remainder
    );

    modport master (
        output i_valid, i_dividend, i_divisor, o_ready,
        input  i_ready, o_valid, o_quotient, o_remainder
    );
endinterface

// File: rtl/divu_iter.sv
// 32-bit restoring unsigned divider, one quotient bit per cycle, using a
// 32-bit carry-lookahead adder as the trial subtractor.
`timescale 1ns/1ps
module cla (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [3:0]  w_gb;
    logic [3:0]  w_pb;
    logic        w_cblk;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // 4-bit lookahead groups; group carries chain between groups
    always_comb begin
        w_c    = '0;
        w_gb   = '0;
        w_pb   = '0;
        w_cblk = i_cin;
        for (int unsigned blk = 0; blk < 8; blk++) begin
            w_gb = w_g[blk*4 +: 4];
            w_pb = w_p[blk*4 +: 4];
            w_c[blk*4]     = w_cblk;
            w_c[blk*4 + 1] = w_gb[0] | (w_pb[0] & w_cblk);
            w_c[blk*4 + 2] = w_gb[1] | (w_pb[1] & w_gb[0])
                           | (w_pb[1] & w_pb[0] & w_cblk);
            w_c[blk*4 + 3] = w_gb[2] | (w_pb[2] & w_gb[1])
                           | (w_pb[2] & w_pb[1] & w_gb[0])
                           | (w_pb[2] & w_pb[1] & w_pb[0] & w_cblk);
            w_cblk         = w_gb[3] | (w_pb[3] & w_gb[2])
                           | (w_pb[3] & w_pb[2] & w_gb[1])
                           | (w_pb[3] & w_pb[2] & w_pb[1] & w_gb[0])
                           | (w_pb[3] & w_pb[2] & w_pb[1] & w_pb[0] & w_cblk);
        end
    end

    assign o_sum = w_p ^ w_c;
endmodule

module divu_iter (
    input  logic        clk,
    input  logic        rst,
    divu_iter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic [31:0] r_divisor;
    logic [4:0]  r_cnt;
    logic        r_i_ready;
    logic        r_o_valid;

    logic [32:0] w_t;
    logic [31:0] w_b;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_ge;

    assign w_t = {r_r, r_q[31]};
    assign w_b = ~r_divisor;

    cla u_cla (
        .i_a   (w_t[31:0]),
        .i_b   (w_b),
        .i_cin (1'b1),
        .o_sum (w_sum)
    );

    // Adder exposes no carry-out; rebuild it from the bit-31 carry-in
    assign w_cout = (w_t[31] & w_b[31])
                  | ((w_t[31] | w_b[31]) & (w_sum[31] ^ w_t[31] ^ w_b[31]));
    assign w_ge   = w_t[32] | w_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_r       <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_i_ready <= 1'b1;
            r_o_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid && r_i_ready) begin
                        r_q       <= bus.i_dividend;
                        r_r       <= '0;
                        r_divisor <= bus.i_divisor;
                        r_cnt     <= '0;
                        r_i_ready <= 1'b0;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_r   <= w_ge ? w_sum : w_t[31:0];
                    r_q   <= {r_q[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_o_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.o_ready) begin
                        r_o_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_i_ready <= 1'b1;
                    r_o_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.i_ready     = r_i_ready;
    assign bus.o_valid     = r_o_valid;
    assign bus.o_quotient  = r_q;
    assign bus.o_remainder = r_r;
endmodule

// File: tb/tb_divu_iter.sv
// Directed bench for divu_iter: hand-computed quotients/remainders, latency,
// backpressure, ignored mid-op operands and asynchronous abort.
`timescale 1ns/1ps
module tb_divu_iter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   lat;

    divu_iter_if bus ();

    divu_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts ticks until o_valid rises, bounded
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.o_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic accept(input logic [31:0] dd, input logic [31:0] ds);
        bus.i_dividend = dd;
        bus.i_divisor  = ds;
        bus.i_valid    = 1'b1;
        chk("accept_ready", {31'd0, bus.i_ready}, 32'd1);
        tick();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.i_valid    = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        bus.o_ready    = 1'b0;
        tick();
        tick();
        chk("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);
        chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_quot", bus.o_quotient, 32'd0);
        chk("rst_rem", bus.o_remainder, 32'd0);
        rst = 1'b0;
        tick();

        // 100 / 7
        bus.o_ready = 1'b1;
        accept(32'd100, 32'd7);
        wait_valid(lat);
        chk("lat_100_7", lat, 32'd32);
        chk("quot_100_7", bus.o_quotient, 32'd14);
        chk("rem_100_7", bus.o_remainder, 32'd2);
        tick();
        chk("post_hs_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, bus.i_ready}, 32'd1);

        // divide by zero
        accept(32'h0000_3039, 32'd0);
        wait_valid(lat);
        chk("lat_div0", lat, 32'd32);
        chk("quot_div0", bus.o_quotient, 32'hFFFF_FFFF);
        chk("rem_div0", bus.o_remainder, 32'h0000_3039);
        tick();

        // back-to-back, i_valid held high throughout
        bus.i_dividend = 32'hFFFF_FFFF; bus.i_divisor = 32'd1; bus.i_valid = 1'b1;
        tick();
        bus.i_dividend = 32'hFFFF_FFFF; bus.i_divisor = 32'hFFFF_FFFF;
        wait_valid(lat);
        chk("lat_ffff_1", lat, 32'd32);
        chk("quot_ffff_1", bus.o_quotient, 32'hFFFF_FFFF);
        chk("rem_ffff_1", bus.o_remainder, 32'd0);
        tick();
        chk("b2b_ready1", {31'd0, bus.i_ready}, 32'd1);
        tick();
        bus.i_dividend = 32'h8000_0000; bus.i_divisor = 32'd3;
        wait_valid(lat);
        chk("quot_ffff_ffff", bus.o_quotient, 32'd1);
        chk("rem_ffff_ffff", bus.o_remainder, 32'd0);
        tick();
        tick();
        bus.i_dividend = 32'd5; bus.i_divisor = 32'd9;
        wait_valid(lat);
        chk("quot_8000_3", bus.o_quotient, 32'h2AAA_AAAA);
        chk("rem_8000_3", bus.o_remainder, 32'd2);
        tick();
        tick();
        bus.i_dividend = 32'd1234; bus.i_divisor = 32'd1;
        wait_valid(lat);
        chk("quot_5_9", bus.o_quotient, 32'd0);
        chk("rem_5_9", bus.o_remainder, 32'd5);
        bus.i_valid = 1'b0;
        tick();

        // backpressure with a stray request pending the whole time
        bus.o_ready = 1'b0;
        accept(32'd1000, 32'd33);
        bus.i_dividend = 32'd77777; bus.i_divisor = 32'd5; bus.i_valid = 1'b1;
        wait_valid(lat);
        chk("lat_bp", lat, 32'd32);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, bus.o_valid}, 32'd1);
            chk("bp_ready", {31'd0, bus.i_ready}, 32'd0);
            chk("bp_quot", bus.o_quotient, 32'd30);
            chk("bp_rem", bus.o_remainder, 32'd10);
            tick();
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        tick();
        chk("bp_hs_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("bp_hs_ready", {31'd0, bus.i_ready}, 32'd1);

        // operands changed and i_valid pulsed mid-op
        accept(32'd12345, 32'd67);
        repeat (5) tick();
        bus.i_dividend = 32'd999; bus.i_divisor = 32'd2; bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        wait_valid(lat);
        chk("lat_midop", lat, 32'd26);
        chk("quot_midop", bus.o_quotient, 32'd184);
        chk("rem_midop", bus.o_remainder, 32'd17);
        tick();

        // asynchronous abort during iteration 10
        accept(32'd50000, 32'd3);
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("abort_ready", {31'd0, bus.i_ready}, 32'd1);
        chk("abort_quot", bus.o_quotient, 32'd0);
        chk("abort_rem", bus.o_remainder, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        accept(32'd77, 32'd7);
        wait_valid(lat);
        chk("lat_77_7", lat, 32'd32);
        chk("quot_77_7", bus.o_quotient, 32'd11);
        chk("rem_77_7", bus.o_remainder, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/divu_iter.md
# divu_iter

Iterative 32-bit unsigned divider that reuses the team's 32-bit carry-lookahead adder (`cla`) as its per-iteration subtractor. It produces one quotient bit per cycle using restoring division. It sits in the execute stage beside the single-cycle adder, consuming operands through a valid/ready handshake and holding its result until the consumer takes it.

## Interface
Parameters:
- none. Width is fixed at 32; the iteration count is fixed at 32.

Ports:
- `clk`  in  1  Sole clock; all state updates on the rising edge.
- `rst`  in  1  Reset, asynchronous and active-high.
- `i_valid`  in  1  Operands present.
- `i_ready`  out  1  Divider can accept operands; high only in IDLE.
- `i_dividend`  in  32  Unsigned dividend.
- `i_divisor`  in  32  Unsigned divisor.
- `o_valid`  out  1  Result present; high only in DONE.
- `o_ready`  in  1  Consumer takes the result.
- `o_quotient`  out  32  Unsigned quotient.
- `o_remainder`  out  32  Unsigned remainder.

## Operation
- States are IDLE, BUSY and DONE. Reset enters IDLE.
- IDLE:
  - `i_ready`=1.
  - When `i_valid`&`i_ready` at an edge, latch the operands. Set quotient/shift register Q=`i_dividend`, R=0, iteration count=0. Go to BUSY.
- BUSY, per edge:
  - T = {R, Q[31]} (33 bits).
  - D = T − divisor. The low 32 bits are formed by a `cla` instance with a=T[31:0], b=~divisor, cin=1.
  - The bit-32 carry-out is reconstructed as (a31&b31)|((a31|b31)&(sum31^a31^b31)).
  - T ≥ divisor iff T[32] | carry-out.
  - If T ≥ divisor: R=D[31:0] and Q={Q[30:0],1}. Otherwise: R=T[31:0] and Q={Q[30:0],0}.
  - Count increments. After the 32nd iteration go to DONE.
- DONE:
  - `o_valid`=1, `o_quotient`=Q, `o_remainder`=R.
  - On `o_valid`&`o_ready` go to IDLE.
  - The result is held stable while `o_ready`=0.
- Divide by zero needs no special case. The algorithm yields quotient 0xFFFFFFFF and remainder = dividend.
- `i_valid` asserted in BUSY or DONE is ignored. Operands are not sampled and the in-flight divide is unaffected.
- No new accept in the same cycle as the output handshake. IDLE is always visited for at least one cycle between operations.

## Timing
- Reset values: `i_ready`=1, `o_valid`=0, `o_quotient`=0, `o_remainder`=0. Internal Q, R and count are 0; state is IDLE.
- Latency: accept at edge E0, iterations at E1..E32, `o_valid`=1 after E32. That is 32 cycles from the accept edge to the visible result.
- Throughput with `o_ready` held high: one divide per 34 cycles (accept, 32 iterations, output handshake).
- The combinational path per iteration is one `cla` plus a 2:1 mux. There is no multi-cycle path.
- Reset asserted in BUSY or DONE aborts immediately and asynchronously. All outputs go to their reset values; the partial result is discarded.
- Outputs in IDLE and BUSY: `o_quotient`/`o_remainder` reflect internal registers but are don't-care; only `o_valid` qualifies them.

## Test plan
- 100/7: accept, `o_ready`=1 → `o_valid` at E32, quotient=14, remainder=2, `i_ready` high again the cycle after handshake.
- 0x3039/0: → quotient=0xFFFFFFFF, remainder=0x00003039.
- Width edges, back-to-back with `i_valid` held high:
  - 0xFFFFFFFF/1 → 0xFFFFFFFF, 0.
  - 0xFFFFFFFF/0xFFFFFFFF → 1, 0.
  - 0x80000000/3 → 0x2AAAAAAA, 2.
  - 5/9 → 0, 5.
- Backpressure: 1000/33, `o_ready`=0 for 5 cycles after `o_valid` → outputs stable (30, 10), `i_ready`=0 and new `i_valid` ignored throughout. Handshake then returns to IDLE.
- Operand change mid-op: alter `i_dividend`/`i_divisor` and pulse `i_valid` during BUSY → result unchanged from originally latched operands.
- Reset mid-op: assert `rst` between clock edges at iteration 10 → `o_valid`=0 and `i_ready`=1 immediately. The next divide (77/7 → 11, 0) is correct.
